// File: rtl/alu8_pkg.sv
// Shared types and constants for the ALU8 datapath blocks.
package alu8_pkg;

  localparam int NIBBLE = 4;
  localparam int WIDTH  = 8;

  // Sequencer states of the nibble-serial adder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/FullAdderVector.sv
// 4-bit ripple-carry adder, shared by both nibble passes of the serial adder.
module FullAdderVector
  import alu8_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] sum,
  output logic              cout
);

  logic [NIBBLE:0] carry;

  // Ripple the carry bit by bit through one full adder per bit.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave a value unassigned and infer a latch.
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < NIBBLE; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[NIBBLE];
  end

endmodule

// File: rtl/nibble_serial_adder8.sv
// 8-bit add/subtract built from one 4-bit adder used twice: low nibble in LOW,
// high nibble in HIGH, with the inter-nibble carry held in carry_q. Operands
// and results move over valid/ready handshakes; no overlap between operations.
module nibble_serial_adder8
  import alu8_pkg::*;
#(
  parameter int WIDTH = alu8_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  state_t state_q;
  state_t state_d;

  // Operands as captured at the accept edge; b is already inverted for sub.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c0_q;
  logic             carry_q;

  logic [NIBBLE-1:0] add_a;
  logic [NIBBLE-1:0] add_b;
  logic              add_cin;
  logic [NIBBLE-1:0] add_sum;
  logic              add_cout;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed LOW -> HIGH -> DONE walk once an operand is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = LOW;
      LOW:                    state_d = HIGH;
      HIGH:                   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake outputs depend on state only, so they can never both be high.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Operand capture at the accept edge; later input changes are ignored.
  always_ff @(posedge clk) begin
    // NOTE: the operand registers carry no reset; they are always loaded on
    // accept before anything reads them, so a reset would only add fan-out.
    if (state_q == IDLE && in_valid) begin
      a_q  <= a;
      b_q  <= sub ? ~b : b;
      c0_q <= sub | cin;
    end
  end

  // Adder input mux: low nibble with the initial carry in LOW, otherwise the
  // high nibble with the carry saved from the low pass.
  always_comb begin
    add_a   = a_q[WIDTH-1:NIBBLE];
    add_b   = b_q[WIDTH-1:NIBBLE];
    add_cin = carry_q;
    if (state_q == LOW) begin
      add_a   = a_q[NIBBLE-1:0];
      add_b   = b_q[NIBBLE-1:0];
      add_cin = c0_q;
    end
  end

  FullAdderVector u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Result and flag registers: low half in LOW, high half and flags in HIGH,
  // held untouched through DONE while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q  <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state_q)
        LOW: begin
          result[NIBBLE-1:0] <= add_sum;
          carry_q            <= add_cout;
        end
        HIGH: begin
          result[WIDTH-1:NIBBLE] <= add_sum;
          cout                   <= add_cout;
          // Same-sign operands producing a result of the other sign.
          overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                      (add_sum[NIBBLE-1] != a_q[WIDTH-1]);
          zero     <= ({add_sum, result[NIBBLE-1:0]} == '0);
        end
        default: ;
      endcase
    end
  end

endmodule
